// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and bus multiplexer in front of the shared memory port.
// Grants are held for a whole client transaction and revoked by a hold-time watchdog.
module mem_rr_arbiter #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_HOLD    = 64
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic [NUM_CLIENTS-1:0]            requests,
  output logic [NUM_CLIENTS-1:0]            grantedAccess,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addressIn,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataIn,
  input  logic [NUM_CLIENTS-1:0]            readWriteIn,
  output logic                              enabled,
  output logic [ADDR_WIDTH-1:0]             address,
  output logic [DATA_WIDTH-1:0]             dataToMem,
  output logic                              readWrite,
  output logic                              timeoutPulse,
  output logic                              busy
);

  localparam int unsigned PTR_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NUM_CLIENTS - 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MAX_HOLD - 1);

  logic                   state_q,   state_d;
  logic [NUM_CLIENTS-1:0] grant_q,   grant_d;
  logic                   enabled_q, enabled_d;
  logic [PTR_W-1:0]       ptr_q,     ptr_d;
  logic [HOLD_W-1:0]      hold_q,    hold_d;
  logic [NUM_CLIENTS-1:0] lockout_q, lockout_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_CLIENTS-1:0] eligible_c;
  logic                   sel_found_c;
  logic [PTR_W-1:0]       sel_idx_c;
  int unsigned            scan_idx;

  // Rotating scan starting just after the last-served client.
  always_comb begin
    eligible_c  = requests & ~lockout_q;
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NUM_CLIENTS) scan_idx = scan_idx - NUM_CLIENTS;
      if (!sel_found_c && eligible_c[PTR_W'(scan_idx)]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = PTR_W'(scan_idx);
      end
    end
  end

  // Next-state logic; ptr_q doubles as the index of the active grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    enabled_d = enabled_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    lockout_d = lockout_q & requests;

    case (state_q)
      ST_IDLE: begin
        if (sel_found_c) begin
          grant_d            = '0;
          grant_d[sel_idx_c] = 1'b1;
          enabled_d          = 1'b1;
          ptr_d              = sel_idx_c;
          hold_d             = '0;
          state_d            = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!requests[ptr_q]) begin
          grant_d   = '0;
          enabled_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (hold_q == HOLD_END) begin
          grant_d          = '0;
          enabled_d        = 1'b0;
          timeout_d        = 1'b1;
          lockout_d[ptr_q] = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        grant_d   = '0;
        enabled_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      enabled_q <= 1'b0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      lockout_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enabled_q <= enabled_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      lockout_q <= lockout_d;
      timeout_q <= timeout_d;
    end
  end

  // One-hot AND-OR mux: all-zero with no grant so memory never sees a stray write.
  always_comb begin
    address   = '0;
    dataToMem = '0;
    readWrite = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) begin
        address   = address   | addressIn[i*ADDR_WIDTH +: ADDR_WIDTH];
        dataToMem = dataToMem | dataIn[i*DATA_WIDTH +: DATA_WIDTH];
        readWrite = readWrite | readWriteIn[i];
      end
    end
  end

  assign grantedAccess = grant_q;
  assign enabled       = enabled_q;
  assign timeoutPulse  = timeout_q;
  assign busy          = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: grant order is scoreboarded, bus/timing checked inline per scenario.
module tb_mem_rr_arbiter;

  localparam int unsigned NC = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned MH = 8;

  logic              clk;
  logic              resetN;
  logic [NC-1:0]     requests;
  logic [NC-1:0]     grantedAccess;
  logic [NC*AW-1:0]  addressIn;
  logic [NC*DW-1:0]  dataIn;
  logic [NC-1:0]     readWriteIn;
  logic              enabled;
  logic [AW-1:0]     address;
  logic [DW-1:0]     dataToMem;
  logic              readWrite;
  logic              timeoutPulse;
  logic              busy;

  int checks;
  int errors;

  logic [AW-1:0] addr_tab [NC];
  logic [DW-1:0] data_tab [NC];
  logic          rw_tab   [NC];

  logic [NC-1:0] exp_q [$];
  logic [NC-1:0] obs_q [$];
  logic [NC-1:0] prev_grant;
  int            obs_base;

  mem_rr_arbiter #(
    .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .resetN(resetN), .requests(requests), .grantedAccess(grantedAccess),
    .addressIn(addressIn), .dataIn(dataIn), .readWriteIn(readWriteIn),
    .enabled(enabled), .address(address), .dataToMem(dataToMem),
    .readWrite(readWrite), .timeoutPulse(timeoutPulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every new grant (rising out of no-grant) as the DUT's output stream.
  initial prev_grant = '0;
  always @(negedge clk) begin
    if (grantedAccess != '0 && prev_grant == '0) obs_q.push_back(grantedAccess);
    prev_grant <= grantedAccess;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic load_fields();
    for (int i = 0; i < NC; i++) begin
      addressIn[i*AW +: AW] = addr_tab[i];
      dataIn[i*DW +: DW]    = data_tab[i];
      readWriteIn[i]        = rw_tab[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN   = 1'b0;
    requests = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sb_start();
    exp_q.delete();
    obs_base = obs_q.size();
  endtask

  task automatic sb_finish(input string name);
    int k;
    logic [NC-1:0] e;
    k = 0;
    checks++;
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++;
      $display("FAIL %s_grant_count: got %0d grants, expected %0d", name, obs_q.size() - obs_base, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_base + k >= obs_q.size()) begin
        errors++;
        $display("FAIL %s_order[%0d]: no grant observed, expected %b", name, k, e);
      end else if (obs_q[obs_base + k] !== e) begin
        errors++;
        $display("FAIL %s_order[%0d]: got %b, expected %b", name, k, obs_q[obs_base + k], e);
      end
      k++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN   = 1'b0;
    requests = 3'b111;
    #1;
    checks++;
    if ({grantedAccess, enabled, busy, timeoutPulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b en=%b busy=%b to=%b, expected all 0", grantedAccess, enabled, busy, timeoutPulse);
    end
    checks++;
    if (address !== '0 || dataToMem !== '0 || readWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h rw=%b, expected 0", address, dataToMem, readWrite);
    end
    requests = '0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_no_grant();
    readWriteIn = 3'b111;
    dataIn      = {32'h11111111, 32'h22222222, 32'h33333333};
    requests    = '0;
    repeat (2) cycle();
    checks++;
    if (readWrite !== 1'b0 || dataToMem !== '0 || enabled !== 1'b0 || address !== '0) begin
      errors++;
      $display("FAIL no_grant_bus: rw=%b data=%h en=%b addr=%h, expected 0", readWrite, dataToMem, enabled, address);
    end
    load_fields();
  endtask

  task automatic test_single();
    int en_cnt;
    do_reset();
    sb_start();
    exp_q.push_back(3'b001);
    requests = 3'b001;
    en_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      if (enabled) en_cnt++;
      if (c == 1) begin
        checks++;
        if (grantedAccess !== 3'b001 || busy !== 1'b1) begin
          errors++;
          $display("FAIL single_latency: grant=%b busy=%b, expected 001/1", grantedAccess, busy);
        end
        checks++;
        if (address !== 8'h05 || dataToMem !== 32'hDEADBEEF || readWrite !== 1'b0) begin
          errors++;
          $display("FAIL single_mux: addr=%h data=%h rw=%b, expected 05/deadbeef/0", address, dataToMem, readWrite);
        end
      end
    end
    requests = '0;
    cycle();
    checks++;
    if (en_cnt != 4) begin
      errors++;
      $display("FAIL single_enable_len: got %0d cycles, expected 4", en_cnt);
    end
    checks++;
    if (grantedAccess !== '0 || enabled !== 1'b0 || busy !== 1'b0 || address !== '0 || dataToMem !== '0) begin
      errors++;
      $display("FAIL single_release: grant=%b en=%b busy=%b addr=%h data=%h, expected 0", grantedAccess, enabled, busy, address, dataToMem);
    end
    cycle();
    sb_finish("single");
  endtask

  task automatic test_round_robin();
    int cnt [NC];
    logic [NC-1:0] g, prev_g;
    do_reset();
    sb_start();
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    prev_g   = '0;
    requests = 3'b111;
    for (int c = 1; c <= 24; c++) begin
      cycle();
      g = grantedAccess;
      if (g != '0 && g != prev_g) begin
        checks++;
        if (prev_g != '0) begin
          errors++;
          $display("FAIL rr_dead_cycle: grant %b followed %b with no idle cycle", g, prev_g);
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (g[i]) begin
          checks++;
          if (address !== addr_tab[i] || dataToMem !== data_tab[i] || readWrite !== rw_tab[i]) begin
            errors++;
            $display("FAIL rr_mux_c%0d: addr=%h data=%h rw=%b, expected %h/%h/%b", i, address, dataToMem, readWrite, addr_tab[i], data_tab[i], rw_tab[i]);
          end
          cnt[i]++;
          if (cnt[i] == 3) begin
            requests[i] = 1'b0;
            cnt[i] = 0;
          end
        end else if (!requests[i]) begin
          requests[i] = 1'b1;
        end
      end
      prev_g = g;
    end
    requests = '0;
    repeat (3) cycle();
    sb_finish("rr");
  endtask

  task automatic test_pointer();
    do_reset();
    sb_start();
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    requests = 3'b010;
    repeat (3) cycle();
    requests = '0;
    repeat (2) cycle();
    requests = 3'b011;
    cycle();
    checks++;
    if (grantedAccess !== 3'b001) begin
      errors++;
      $display("FAIL pointer_next: grant=%b, expected 001", grantedAccess);
    end
    requests = 3'b010;
    repeat (4) cycle();
    requests = '0;
    repeat (3) cycle();
    sb_finish("pointer");
  endtask

  task automatic test_timeout();
    int g2_cnt, pulse_cnt, pulse_cyc, c0_cnt;
    bit c0_done;
    do_reset();
    sb_start();
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    g2_cnt = 0; pulse_cnt = 0; pulse_cyc = -1; c0_cnt = 0; c0_done = 0;
    requests = 3'b100;
    for (int c = 1; c <= 28; c++) begin
      cycle();
      if (grantedAccess[2] && c <= 20) g2_cnt++;
      if (timeoutPulse) begin
        pulse_cnt++;
        pulse_cyc = c;
        checks++;
        if (grantedAccess !== 3'b000 && grantedAccess !== 3'b001) begin
          errors++;
          $display("FAIL timeout_pulse_grant: grant=%b during pulse, expected client 2 released", grantedAccess);
        end
      end
      if (c == 4) requests[0] = 1'b1;
      if (grantedAccess[0]) begin
        c0_cnt++;
        if (c0_cnt == 3) begin
          requests[0] = 1'b0;
          c0_done = 1;
        end
      end
      if (c == 20) requests[2] = 1'b0;
      if (c == 22) requests[2] = 1'b1;
      if (c > 22 && grantedAccess[2]) requests[2] = 1'b0;
    end
    requests = '0;
    repeat (2) cycle();
    checks++;
    if (g2_cnt != MH) begin
      errors++;
      $display("FAIL timeout_hold_len: got %0d cycles, expected %0d", g2_cnt, MH);
    end
    checks++;
    if (pulse_cnt != 1 || pulse_cyc != 9) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 9", pulse_cnt, pulse_cyc);
    end
    checks++;
    if (!c0_done) begin
      errors++;
      $display("FAIL timeout_other_client: got client 0 served=%0d, expected 1", c0_done);
    end
    sb_finish("timeout");
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb_start();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    readWriteIn = 3'b001;
    requests    = 3'b001;
    cycle();
    checks++;
    if (readWrite !== 1'b1 || grantedAccess !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_pre: rw=%b grant=%b, expected 1/001", readWrite, grantedAccess);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (grantedAccess !== '0 || enabled !== 1'b0 || readWrite !== 1'b0 || busy !== 1'b0 || dataToMem !== '0) begin
      errors++;
      $display("FAIL rstmid_async: grant=%b en=%b rw=%b busy=%b data=%h, expected 0", grantedAccess, enabled, readWrite, busy, dataToMem);
    end
    @(negedge clk);
    resetN   = 1'b1;
    requests = 3'b011;
    cycle();
    checks++;
    if (grantedAccess !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_first: grant=%b, expected 001", grantedAccess);
    end
    requests = '0;
    repeat (3) cycle();
    load_fields();
    sb_finish("rstmid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    addr_tab[0] = 8'h05; data_tab[0] = 32'hDEADBEEF; rw_tab[0] = 1'b0;
    addr_tab[1] = 8'h2A; data_tab[1] = 32'h12345678; rw_tab[1] = 1'b1;
    addr_tab[2] = 8'h7C; data_tab[2] = 32'hCAFEF00D; rw_tab[2] = 1'b1;
    resetN   = 1'b0;
    requests = '0;
    load_fields();
    test_reset();
    test_no_grant();
    test_single();
    test_round_robin();
    test_pointer();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter and bus multiplexer between the memory clients (reader, atomic incrementers) and the shared 32-bit memory. Each client holds its request for a whole multi-cycle transaction, so a read-modify-write stays atomic. The block grants one client at a time and routes that client's address, write data and read/write strobe to the memory port. A hold-time watchdog revokes any grant held longer than a set number of cycles.

## Interface
- NUM_CLIENTS, 3, number of requesters (2..8)
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 32, memory data width
- MAX_HOLD, 64, max cycles a grant may be held before revocation (>=2)
- clk  in  1  system clock; all state on rising edge
- resetN  in  1  asynchronous active-low reset
- requests  in  NUM_CLIENTS  per-client request, held for whole transaction
- grantedAccess  out  NUM_CLIENTS  one-hot grant, registered
- addressIn  in  NUM_CLIENTS*ADDR_WIDTH  client addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- dataIn  in  NUM_CLIENTS*DATA_WIDTH  client write data, same packing
- readWriteIn  in  NUM_CLIENTS  client strobe, 1 = write
- enabled  out  1  memory enable, registered, high exactly while a grant is active
- address  out  ADDR_WIDTH  muxed address to memory
- dataToMem  out  DATA_WIDTH  muxed write data
- readWrite  out  1  muxed write strobe
- timeoutPulse  out  1  one-cycle pulse on watchdog revocation
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Reset: IDLE, grantedAccess=0, enabled=0, busy=0, timeoutPulse=0, pointer=NUM_CLIENTS-1 (client 0 wins first), holdCount=0, lockout=0.
- IDLE: eligible = requests & ~lockout. If eligible is zero, stay. Otherwise scan from pointer+1, wrapping modulo NUM_CLIENTS, and pick the first eligible client g. On the edge: grantedAccess<=onehot(g), enabled<=1, pointer<=g, holdCount<=0, go to GRANT.
- GRANT, requests[g] low: release. grantedAccess<=0, enabled<=0, go to IDLE.
- GRANT, requests[g] high and holdCount==MAX_HOLD-1: revoke. Same register effects as release, plus timeoutPulse<=1 and lockout[g]<=1.
- GRANT, otherwise: holdCount++.
- lockout[i] clears on any edge where requests[i] is sampled low. A revoked client is not re-granted until it has dropped its request for at least one cycle.
- Mux, combinational from grantedAccess: address/dataToMem/readWrite = granted client's fields. All zero when no grant, so the memory never sees a stray write.
- Simultaneous requests: resolved by rotation only. No fixed priority beyond the pointer.
- Requests from non-granted clients during GRANT are ignored. They are evaluated on the first IDLE cycle.
- Reset mid-transaction: all outputs drop asynchronously. The in-flight access is abandoned and the client must re-request.

## Timing
- Request to grant: request sampled high at edge N in IDLE; grantedAccess/enabled high after edge N (1-cycle latency).
- Release: requests[g] sampled low at edge M; grant/enabled low after edge M.
- At least one IDLE cycle between consecutive grants. Back-to-back transactions cost one dead cycle.
- Max hold: a grant stays high for at most MAX_HOLD cycles.
- timeoutPulse is high for exactly one cycle, coincident with the first cycle grant is low.
- Mux outputs follow client inputs combinationally during grant. Clients must present stable fields while granted.

## Test plan
- Single client: requests=3'b001 for 4 cycles → grantedAccess=001 one cycle after, enabled high 4 cycles, address/dataToMem mirror client 0 (e.g. 0x05 / 0xDEADBEEF), zero after release.
- All three request continuously with 3-cycle transactions → grants in order 0,1,2,0,1,2 with one idle cycle between each; no client is granted twice in a row while others wait.
- Pointer=1 (client 1 just served), clients 0 and 1 request → client 0 is granted next.
- MAX_HOLD=8, client 2 holds request 20 cycles → grant revoked after 8 cycles, timeoutPulse exactly 1 cycle, client 2 not re-granted until it drops its request; client 0 requesting meanwhile is granted.
- Reset asserted mid-grant with readWrite=1 → grantedAccess=0, enabled=0, readWrite=0 immediately (asynchronous); after release, client 0 wins first.
- No grant: assert readWriteIn=3'b111 with nonzero data → readWrite=0, dataToMem=0, enabled=0.
